// File: rtl/score_display_renderer.sv
// Score renderer: binary score in via valid/ready, iterative double-dabble to BCD,
// frame-synchronous commit of the digits, and a 2-stage per-pixel glyph lookup.
module score_display_renderer #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 14,
  parameter int ORIGIN_X    = 400,
  parameter int ORIGIN_Y    = 100,
  parameter int SCALE_SHIFT = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic               frame_start,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  output logic               pixel_on,
  output logic [3:0]         rom_number,
  input  logic [79:0]        rom_data
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BOX_W = (NUM_DIGITS * 8) << SCALE_SHIFT;
  localparam int BOX_H = 10 << SCALE_SHIFT;

  function automatic longint max_score(input int nd);
    longint m;
    m = 64'sd1;
    for (int i = 0; i < nd; i++) begin
      m = m * 64'sd10;
    end
    return m - 64'sd1;
  endfunction

  localparam longint SCORE_MAX = max_score(NUM_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_PENDING = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [BCD_W-1:0]   bcd_adj_s;
  logic [SCORE_W-1:0] sat_s;

  logic [10:0]           rel_x_s, rel_y_s;
  logic                  in_box_s;
  logic [IDX_W-1:0]      idx_s;
  logic [2:0]            col_s;
  logic [3:0]            row_s;
  logic [NUM_DIGITS-1:0] blank_s;
  logic                  lead_zero_s;
  logic [6:0]            bit_idx_s;
  logic [3:0]            rom_num_s;

  logic                  in_box_q;
  logic [IDX_W-1:0]      idx_q;
  logic [2:0]            col_q;
  logic [3:0]            row_q;
  logic                  blank_q;
  logic                  pixel_on_q;

  assign sat_s = (64'(score_in) > 64'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_in;
  assign score_ready = (state_q == S_IDLE);

  // Score FSM: accept, convert one bit per cycle, then wait for a frame boundary to commit.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    bcd_adj_s = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (score_valid) begin
          score_d = sat_s;
          bcd_d   = '0;
          cnt_d   = CNT_W'(SCORE_W);
          state_d = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          bcd_adj_s[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                          : bcd_q[4*i +: 4];
        end
        // Top bit falls off the shift; saturation keeps the value in range.
        bcd_d   = (bcd_adj_s << 1) | BCD_W'(score_q[SCORE_W-1]);
        score_d = score_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_PENDING;
        end else begin
          state_d = S_CONVERT;
        end
      end
      S_PENDING: begin
        if (frame_start) begin
          disp_d  = bcd_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_PENDING;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Score FSM and conversion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      score_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Leading-zero blank mask; digit 0 is leftmost, the rightmost digit always shows.
  always_comb begin
    blank_s     = '0;
    lead_zero_s = (BLANK_LZ != 0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero_s = lead_zero_s && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      blank_s[i]  = lead_zero_s && (i != NUM_DIGITS - 1);
    end
  end

  // Stage-1 address decode of the scan position into digit/column/row.
  always_comb begin
    rel_x_s  = {1'b0, pixel_x} - 11'(ORIGIN_X);
    rel_y_s  = {1'b0, pixel_y} - 11'(ORIGIN_Y);
    in_box_s = !rel_x_s[10] && !rel_y_s[10] &&
               (rel_x_s < 11'(BOX_W)) && (rel_y_s < 11'(BOX_H));
    if (in_box_s) begin
      idx_s = rel_x_s[SCALE_SHIFT+3 +: IDX_W];
      col_s = rel_x_s[SCALE_SHIFT +: 3];
      row_s = rel_y_s[SCALE_SHIFT +: 4];
    end else begin
      idx_s = '0;
      col_s = 3'd0;
      row_s = 4'd0;
    end
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_q <= 1'b0;
      idx_q    <= '0;
      col_q    <= 3'd0;
      row_q    <= 4'd0;
      blank_q  <= 1'b0;
    end else begin
      in_box_q <= in_box_s;
      idx_q    <= idx_s;
      col_q    <= col_s;
      row_q    <= row_s;
      blank_q  <= blank_s[idx_s];
    end
  end

  // Digit value for the font ROM, selected by the stage-1 digit index.
  always_comb begin
    rom_num_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      rom_num_s = (idx_q == IDX_W'(i)) ? disp_q[4*(NUM_DIGITS-1-i) +: 4] : rom_num_s;
    end
  end

  assign rom_number = rom_num_s;
  assign bit_idx_s  = 7'd79 - {row_q, 3'b000} - {4'b0000, col_q};

  // Stage-2: pick the glyph bit for this row/column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on_q <= 1'b0;
    end else begin
      pixel_on_q <= in_box_q && !blank_q && rom_data[bit_idx_s];
    end
  end

  assign pixel_on = pixel_on_q;

endmodule

// File: tb/tb_score_display_renderer.sv
// Directed self-checking bench for score_display_renderer with a behavioural font ROM.
module tb_score_display_renderer;

  localparam int SX0 = 398;
  localparam int SY0 = 98;
  localparam int SW  = 68;
  localparam int SH  = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] score_in;
  logic        score_valid;
  logic        score_ready;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_on;
  logic [3:0]  rom_number;
  logic [79:0] rom_data;

  int vectors = 0;
  int miscompares = 0;
  int md[4];
  logic obs[SH][SW];

  score_display_renderer dut (
    .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
    .score_ready(score_ready), .frame_start(frame_start), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_on(pixel_on), .rom_number(rom_number), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] font(input logic [3:0] d);
    case (d)
      4'd0: font = 80'h3C66_6666_6666_6666_3C00;
      4'd1: font = 80'h1838_1818_1818_1818_7E00;
      4'd2: font = 80'h3C66_060C_1830_6066_7E00;
      4'd3: font = 80'h3C66_061C_0606_0666_3C00;
      4'd4: font = 80'h0C1C_3C6C_CCFE_0C0C_1E00;
      4'd5: font = 80'h7E60_607C_0606_0666_3C00;
      4'd6: font = 80'h1C30_607C_6666_6666_3C00;
      4'd7: font = 80'h7E66_060C_1818_1818_1800;
      4'd8: font = 80'h3C66_663C_6666_6666_3C00;
      4'd9: font = 80'h3C66_6666_3E06_060C_3800;
      default: font = 80'h0;
    endcase
  endfunction

  always_comb rom_data = font(rom_number);

  // Expected screen image for the digits in md[] (md[0] leftmost).
  function automatic logic model_pixel(input int x, input int y);
    int rx, ry, d, col, row;
    logic lz;
    logic [79:0] g;
    rx = x - 400;
    ry = y - 100;
    if (rx < 0 || ry < 0 || rx >= 64 || ry >= 20) return 1'b0;
    d   = (rx / 2) / 8;
    col = (rx / 2) % 8;
    row = ry / 2;
    lz  = 1'b1;
    for (int i = 0; i <= d; i++) lz = lz && (md[i] == 0);
    if (lz && d != 3) return 1'b0;
    g = font(4'(md[d]));
    return g[79 - 8*row - col];
  endfunction

  task automatic set_md(input int a, input int b, input int c, input int d);
    md[0] = a; md[1] = b; md[2] = c; md[3] = d;
  endtask

  // Pipelined scan, one new query per cycle; output collected two cycles later.
  task automatic scan();
    for (int k = 0; k < SW*SH + 2; k++) begin
      @(negedge clk);
      if (k >= 2) obs[(k-2)/SW][(k-2)%SW] = pixel_on;
      if (k < SW*SH) begin
        pixel_x = 10'(SX0 + k % SW);
        pixel_y = 10'(SY0 + k / SW);
      end
    end
  endtask

  task automatic query(input int x, input int y, output logic [3:0] rn, output logic pon);
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    @(negedge clk);
    rn = rom_number;
    @(negedge clk);
    pon = pixel_on;
  endtask

  task automatic load(input int v, input int fs_edge, input int fs_extra, input int alt_v,
                      input int alt_cycles, input int limit, output int lowcnt);
    @(negedge clk);
    score_in = 14'(v);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    lowcnt = 0;
    for (int c = 1; c <= limit; c++) begin
      if (score_ready) break;
      lowcnt++;
      frame_start = (c == fs_edge) || (c == fs_extra);
      score_valid = (c <= alt_cycles);
      if (c <= alt_cycles) score_in = 14'(alt_v);
      @(negedge clk);
    end
    frame_start = 1'b0;
    score_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", score_ready); end
    vectors++;
    if (pixel_on !== 1'b0) begin miscompares++; $display("FAIL reset_pixel got %b want 0", pixel_on); end
    vectors++;
    if (rom_number !== 4'd0) begin miscompares++; $display("FAIL reset_rom got %0d want 0", rom_number); end
    rst_n = 1'b1;
    set_md(0, 0, 0, 0);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL reset_scan (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_load_1234();
    int lc;
    logic [3:0] rn;
    logic pon;
    load(1234, 15, 5, 0, 0, 40, lc);
    vectors++;
    if (lc !== 15) begin miscompares++; $display("FAIL busy_cycles got %0d want 15", lc); end
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_commit got %b want 1", score_ready); end
    query(400, 100, rn, pon);
    vectors++;
    if (rn !== 4'd1) begin miscompares++; $display("FAIL rom_400_100 got %0d want 1", rn); end
    vectors++;
    if (pon !== 1'b0) begin miscompares++; $display("FAIL pix_400_100 got %b want 0", pon); end
    query(406, 100, rn, pon);
    vectors++;
    if (pon !== 1'b1) begin miscompares++; $display("FAIL pix_406_100 got %b want 1", pon); end
    set_md(1, 2, 3, 4);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_1234 (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_saturate();
    int lc;
    logic [3:0] rn;
    logic pon;
    load(12000, 15, 0, 0, 0, 40, lc);
    query(400, 100, rn, pon);
    vectors++;
    if (rn !== 4'd9) begin miscompares++; $display("FAIL sat_digit0 got %0d want 9", rn); end
    query(460, 110, rn, pon);
    vectors++;
    if (rn !== 4'd9) begin miscompares++; $display("FAIL sat_digit3 got %0d want 9", rn); end
    set_md(9, 9, 9, 9);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_9999 (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    logic [3:0] rn;
    logic pon;
    load(0, 15, 0, 0, 0, 40, lc);
    score_in = 14'd7;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    vectors++;
    if (score_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got %b want 0", score_ready); end
    repeat (14) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_commit got %b want 1", score_ready); end
    query(450, 100, rn, pon);
    vectors++;
    if (rn !== 4'd7 || pon !== 1'b1) begin miscompares++; $display("FAIL pix_450_100 got %0d/%b want 7/1", rn, pon); end
    query(402, 102, rn, pon);
    vectors++;
    if (pon !== 1'b0) begin miscompares++; $display("FAIL blank_402_102 got %b want 0", pon); end
    set_md(0, 0, 0, 7);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_0007 (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_zero();
    int lc;
    load(0, 15, 0, 0, 0, 40, lc);
    set_md(0, 0, 0, 0);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_0000 (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lc;
    load(5678, 0, 3, 1111, 10, 114, lc);
    vectors++;
    if (lc !== 114 || score_ready !== 1'b0) begin
      miscompares++; $display("FAIL pending_hold got %0d/%b want 114/0", lc, score_ready);
    end
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_unchanged (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL late_commit got %b want 1", score_ready); end
    set_md(5, 6, 7, 8);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_5678 (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] rn;
    logic pon;
    @(negedge clk);
    score_in = 14'd4321;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready got %b want 1", score_ready); end
    vectors++;
    if (rom_number !== 4'd0) begin miscompares++; $display("FAIL midreset_rom got %0d want 0", rom_number); end
    @(negedge clk);
    rst_n = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++;
    if (score_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_idle got %b want 1", score_ready); end
    query(399, 100, rn, pon);
    vectors++;
    if (pon !== 1'b0) begin miscompares++; $display("FAIL pix_399_100 got %b want 0", pon); end
    query(464, 100, rn, pon);
    vectors++;
    if (pon !== 1'b0) begin miscompares++; $display("FAIL pix_464_100 got %b want 0", pon); end
    set_md(0, 0, 0, 0);
    scan();
    for (int r = 0; r < SH; r++) for (int c = 0; c < SW; c++) begin
      vectors++;
      if (obs[r][c] !== model_pixel(SX0+c, SY0+r)) begin
        miscompares++; $display("FAIL scan_after_reset (%0d,%0d) got %b want %b", SX0+c, SY0+r, obs[r][c], model_pixel(SX0+c, SY0+r));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    score_in = 14'd0;
    score_valid = 1'b0;
    frame_start = 1'b0;
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    test_reset();
    test_load_1234();
    test_saturate();
    test_back_to_back();
    test_zero();
    test_ignore_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
